// File: rtl/riscv_pkg.sv
// Shared types for the branch-history tracker: in-flight entry layout and an
// integrity helper for the padded history field.
package riscv_pkg;

   // Widest global history the entry layout can carry; narrower histories are zero-padded.
   localparam int unsigned BP_HIST_MAX = 8;

   typedef struct packed {
      logic [BP_HIST_MAX-1:0] history;
      logic [1:0]             predict;
   } bp_entry_t;

   // Any set bit above the live history width means the stored entry is corrupt.
   function automatic logic hist_pad_dirty(input bp_entry_t e, input int unsigned g);
      logic acc;
      acc = 1'b0;
      for (int unsigned i = 0; i < BP_HIST_MAX; i++) begin
         if (i >= g) begin
            acc = acc | e.history[i];
         end
      end
      return acc;
   endfunction

endpackage

// File: rtl/riscv_bp_hist_if.sv
// Branch-history tracker bus: fetch-side push, EX-side resolve, flush and the
// predictor write port.
interface riscv_bp_hist_if #(
   parameter int unsigned BP_GLOBAL_BITS = 2
);
   logic                      if_br_push;
   logic [1:0]                if_br_predict;
   logic [BP_GLOBAL_BITS-1:0] bp_history;
   logic                      bp_full;
   logic                      ex_br_resolve;
   logic                      ex_br_taken;
   logic                      pipe_flush;
   logic [BP_GLOBAL_BITS-1:0] bu_bp_history;
   logic [1:0]                bu_bp_predict;
   logic                      bu_bp_btaken;
   logic                      bu_bp_update;
   logic                      bp_mispredict;
   logic                      bp_err;

   modport master (
      output if_br_push, if_br_predict, ex_br_resolve, ex_br_taken, pipe_flush,
      input  bp_history, bp_full, bu_bp_history, bu_bp_predict, bu_bp_btaken,
             bu_bp_update, bp_mispredict, bp_err
   );

   modport slave (
      input  if_br_push, if_br_predict, ex_br_resolve, ex_br_taken, pipe_flush,
      output bp_history, bp_full, bu_bp_history, bu_bp_predict, bu_bp_btaken,
             bu_bp_update, bp_mispredict, bp_err
   );
endinterface

// File: rtl/riscv_bp_queue.sv
// In-flight branch FIFO: power-of-two ring with registered empty/full flags
// and a synchronous clear that overrides push and pop.
module riscv_bp_queue
   import riscv_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic      clk,
   input  logic      rstn,
   input  logic      clear,
   input  logic      push,
   input  logic      pop,
   input  bp_entry_t push_data,
   output bp_entry_t head,
   output logic      empty,
   output logic      full
);
   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;

   bp_entry_t         mem_r [DEPTH];
   logic [PW-1:0]     wr_ptr_r;
   logic [PW-1:0]     rd_ptr_r;
   logic [CW-1:0]     count_r;
   logic [CW-1:0]     count_nxt_s;
   logic              empty_r;
   logic              full_r;

   // Next occupancy; the caller never pops empty nor pushes full without a pop.
   always_comb begin
      count_nxt_s = count_r;
      if (clear) begin
         count_nxt_s = '0;
      end else begin
         case ({push, pop})
            2'b10:   count_nxt_s = count_r + CW'(1);
            2'b01:   count_nxt_s = count_r - CW'(1);
            default: count_nxt_s = count_r;
         endcase
      end
   end

   // Storage, ring pointers and occupancy flags.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem_r[i] <= '0;
         end
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
         count_r  <= '0;
         empty_r  <= 1'b1;
         full_r   <= 1'b0;
      end else begin
         if (clear) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
         end else begin
            if (push) begin
               mem_r[wr_ptr_r] <= push_data;
               wr_ptr_r        <= wr_ptr_r + PW'(1);
            end
            if (pop) begin
               rd_ptr_r <= rd_ptr_r + PW'(1);
            end
         end
         count_r <= count_nxt_s;
         empty_r <= (count_nxt_s == CW'(0));
         full_r  <= (count_nxt_s == CW'(DEPTH));
      end
   end

   assign head  = mem_r[rd_ptr_r];
   assign empty = empty_r;
   assign full  = full_r;

endmodule

// File: rtl/riscv_bp_hist.sv
// Speculative/committed global branch history with an in-flight entry queue
// that replays each branch's snapshot to the predictor when it resolves.
module riscv_bp_hist
   import riscv_pkg::*;
#(
   parameter int unsigned XLEN           = 32,
   parameter int unsigned BP_GLOBAL_BITS = 2,
   parameter int unsigned DEPTH          = 4
) (
   input  logic            clk,
   input  logic            rstn,
   riscv_bp_hist_if.slave  bp
);
   localparam int unsigned G = BP_GLOBAL_BITS;

   if (G < 2 || G > BP_HIST_MAX) begin : g_bad_hist
      $error("riscv_bp_hist: BP_GLOBAL_BITS out of range");
   end
   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("riscv_bp_hist: DEPTH must be a power of two >= 2");
   end
   if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
      $error("riscv_bp_hist: XLEN must be 32 or 64");
   end

   logic [G-1:0] spec_ghr_r;
   logic [G-1:0] commit_ghr_r;
   logic [G-1:0] spec_ghr_nxt_s;
   logic [G-1:0] commit_ghr_nxt_s;
   bp_entry_t    head_s;
   bp_entry_t    push_entry_s;
   logic         q_empty_s;
   logic         q_full_s;
   logic         resolve_ok_s;
   logic         mispred_s;
   logic         kill_s;
   logic         push_room_s;
   logic         push_acc_s;
   logic         err_s;

   logic         bu_update_r;
   logic [G-1:0] bu_history_r;
   logic [1:0]   bu_predict_r;
   logic         bu_btaken_r;
   logic         mispredict_r;
   logic         err_r;

   // A full queue still takes a push when a correct resolve frees the head slot.
   always_comb begin
      push_entry_s               = '0;
      push_entry_s.history[G-1:0] = spec_ghr_r;
      push_entry_s.predict       = bp.if_br_predict;
      resolve_ok_s = bp.ex_br_resolve & ~q_empty_s;
      mispred_s    = resolve_ok_s & (head_s.predict[1] ^ bp.ex_br_taken);
      kill_s       = mispred_s | bp.pipe_flush;
      push_room_s  = ~q_full_s | (resolve_ok_s & ~mispred_s);
      push_acc_s   = bp.if_br_push & push_room_s & ~kill_s;
      err_s        = (bp.if_br_push & ~push_room_s)
                   | (bp.ex_br_resolve & q_empty_s)
                   | (resolve_ok_s & hist_pad_dirty(head_s, G));
      if (resolve_ok_s) begin
         commit_ghr_nxt_s = {commit_ghr_r[G-2:0], bp.ex_br_taken};
      end else begin
         commit_ghr_nxt_s = commit_ghr_r;
      end
      if (kill_s) begin
         spec_ghr_nxt_s = commit_ghr_nxt_s;
      end else if (push_acc_s) begin
         spec_ghr_nxt_s = {spec_ghr_r[G-2:0], bp.if_br_predict[1]};
      end else begin
         spec_ghr_nxt_s = spec_ghr_r;
      end
   end

   riscv_bp_queue #(
      .DEPTH (DEPTH)
   ) u_queue (
      .clk       (clk),
      .rstn      (rstn),
      .clear     (kill_s),
      .push      (push_acc_s),
      .pop       (resolve_ok_s),
      .push_data (push_entry_s),
      .head      (head_s),
      .empty     (q_empty_s),
      .full      (q_full_s)
   );

   // History registers, predictor write port and sticky error.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         spec_ghr_r   <= '0;
         commit_ghr_r <= '0;
         bu_update_r  <= 1'b0;
         bu_history_r <= '0;
         bu_predict_r <= 2'b00;
         bu_btaken_r  <= 1'b0;
         mispredict_r <= 1'b0;
         err_r        <= 1'b0;
      end else begin
         spec_ghr_r   <= spec_ghr_nxt_s;
         commit_ghr_r <= commit_ghr_nxt_s;
         bu_update_r  <= resolve_ok_s;
         err_r        <= err_r | err_s;
         if (resolve_ok_s) begin
            bu_history_r <= head_s.history[G-1:0];
            bu_predict_r <= head_s.predict;
            bu_btaken_r  <= bp.ex_br_taken;
            mispredict_r <= mispred_s;
         end
      end
   end

   assign bp.bp_history    = spec_ghr_r;
   assign bp.bp_full       = q_full_s;
   assign bp.bu_bp_update  = bu_update_r;
   assign bp.bu_bp_history = bu_history_r;
   assign bp.bu_bp_predict = bu_predict_r;
   assign bp.bu_bp_btaken  = bu_btaken_r;
   assign bp.bp_mispredict = mispredict_r;
   assign bp.bp_err        = err_r;

endmodule

// File: tb/tb_riscv_bp_hist.sv
// Directed bench for riscv_bp_hist (G=2, DEPTH=4) with hand-computed expectations.
module tb_riscv_bp_hist;
   logic clk;
   logic rstn;
   int   errors = 0;
   int   checks = 0;

   riscv_bp_hist_if #(.BP_GLOBAL_BITS(2)) bus ();

   riscv_bp_hist #(
      .XLEN           (32),
      .BP_GLOBAL_BITS (2),
      .DEPTH          (4)
   ) dut (
      .clk  (clk),
      .rstn (rstn),
      .bp   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_upd(input string tag, input logic upd, input logic [1:0] hist,
                          input logic [1:0] pred, input logic btk, input logic mis);
      chk({tag, ".update"},  8'(bus.bu_bp_update),  8'(upd));
      chk({tag, ".history"}, 8'(bus.bu_bp_history), 8'(hist));
      chk({tag, ".predict"}, 8'(bus.bu_bp_predict), 8'(pred));
      chk({tag, ".btaken"},  8'(bus.bu_bp_btaken),  8'(btk));
      chk({tag, ".mispred"}, 8'(bus.bp_mispredict), 8'(mis));
   endtask

   task automatic cyc(input logic push, input logic [1:0] pred, input logic res,
                      input logic tk, input logic fl);
      bus.if_br_push    = push;
      bus.if_br_predict = pred;
      bus.ex_br_resolve = res;
      bus.ex_br_taken   = tk;
      bus.pipe_flush    = fl;
      @(posedge clk);
      #1;
      bus.if_br_push    = 1'b0;
      bus.if_br_predict = 2'b00;
      bus.ex_br_resolve = 1'b0;
      bus.ex_br_taken   = 1'b0;
      bus.pipe_flush    = 1'b0;
   endtask

   task automatic do_reset();
      rstn = 1'b0;
      @(posedge clk);
      #1;
      rstn = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rstn              = 1'b0;
      bus.if_br_push    = 1'b0;
      bus.if_br_predict = 2'b00;
      bus.ex_br_resolve = 1'b0;
      bus.ex_br_taken   = 1'b0;
      bus.pipe_flush    = 1'b0;
      @(posedge clk);
      #1;
      chk("rst.history", 8'(bus.bp_history), 8'h00);
      chk("rst.full",    8'(bus.bp_full),    8'h00);
      chk("rst.err",     8'(bus.bp_err),     8'h00);
      chk_upd("rst", 1'b0, 2'b00, 2'b00, 1'b0, 1'b0);
      rstn = 1'b1;

      // Single push then correct taken resolve; commit observed through a flush.
      cyc(1'b1, 2'b10, 1'b0, 1'b0, 1'b0);
      chk("basic.spec", 8'(bus.bp_history), 8'h01);
      cyc(1'b0, 2'b00, 1'b1, 1'b1, 1'b0);
      chk_upd("basic.upd", 1'b1, 2'b00, 2'b10, 1'b1, 1'b0);
      chk("basic.spec_keep", 8'(bus.bp_history), 8'h01);
      cyc(1'b1, 2'b00, 1'b0, 1'b0, 1'b0);
      chk("basic.pulse_end", 8'(bus.bu_bp_update), 8'h00);
      chk("basic.spec2", 8'(bus.bp_history), 8'h02);
      cyc(1'b0, 2'b00, 1'b0, 1'b0, 1'b1);
      chk("basic.commit", 8'(bus.bp_history), 8'h01);
      chk("basic.err", 8'(bus.bp_err), 8'h00);

      // Fill, overflow drop, then drain exactly four entries.
      do_reset();
      for (int i = 0; i < 4; i++) begin
         cyc(1'b1, 2'b00, 1'b0, 1'b0, 1'b0);
         chk("fill.full", 8'(bus.bp_full), (i == 3) ? 8'h01 : 8'h00);
      end
      cyc(1'b1, 2'b10, 1'b0, 1'b0, 1'b0);
      chk("ovf.err",     8'(bus.bp_err),     8'h01);
      chk("ovf.full",    8'(bus.bp_full),    8'h01);
      chk("ovf.history", 8'(bus.bp_history), 8'h00);
      for (int i = 0; i < 4; i++) begin
         cyc(1'b0, 2'b00, 1'b1, 1'b0, 1'b0);
         chk_upd("drain", 1'b1, 2'b00, 2'b00, 1'b0, 1'b0);
         chk("drain.full", 8'(bus.bp_full), 8'h00);
      end
      cyc(1'b0, 2'b00, 1'b1, 1'b0, 1'b0);
      chk("drain.empty_upd", 8'(bus.bu_bp_update), 8'h00);

      // Mispredict empties the queue and restores the committed history.
      do_reset();
      cyc(1'b1, 2'b10, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 2'b00, 1'b0, 1'b0, 1'b0);
      chk("mis.spec", 8'(bus.bp_history), 8'h02);
      cyc(1'b0, 2'b00, 1'b1, 1'b0, 1'b0);
      chk_upd("mis.upd", 1'b1, 2'b00, 2'b10, 1'b0, 1'b1);
      chk("mis.history", 8'(bus.bp_history), 8'h00);
      chk("mis.err0",    8'(bus.bp_err),     8'h00);
      cyc(1'b0, 2'b00, 1'b1, 1'b1, 1'b0);
      chk("mis.no_upd", 8'(bus.bu_bp_update), 8'h00);
      chk("mis.err1",   8'(bus.bp_err),       8'h01);

      // Flush with a same-cycle push.
      do_reset();
      cyc(1'b1, 2'b11, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 2'b11, 1'b0, 1'b0, 1'b0);
      chk("flush.spec", 8'(bus.bp_history), 8'h03);
      cyc(1'b1, 2'b10, 1'b0, 1'b0, 1'b1);
      chk("flush.history", 8'(bus.bp_history), 8'h00);
      chk("flush.update",  8'(bus.bu_bp_update), 8'h00);
      cyc(1'b0, 2'b00, 1'b1, 1'b1, 1'b0);
      chk("flush.empty", 8'(bus.bu_bp_update), 8'h00);
      chk("flush.err",   8'(bus.bp_err),       8'h01);

      // Full queue with same-cycle push and correct resolve.
      do_reset();
      for (int i = 0; i < 4; i++) begin
         cyc(1'b1, 2'b10, 1'b0, 1'b0, 1'b0);
      end
      chk("swap.full0", 8'(bus.bp_full),    8'h01);
      chk("swap.spec0", 8'(bus.bp_history), 8'h03);
      cyc(1'b1, 2'b10, 1'b1, 1'b1, 1'b0);
      chk("swap.full1", 8'(bus.bp_full), 8'h01);
      chk("swap.err",   8'(bus.bp_err),  8'h00);
      chk_upd("swap.upd", 1'b1, 2'b00, 2'b10, 1'b1, 1'b0);
      cyc(1'b0, 2'b00, 1'b1, 1'b1, 1'b0);
      chk_upd("swap.d1", 1'b1, 2'b01, 2'b10, 1'b1, 1'b0);
      cyc(1'b0, 2'b00, 1'b1, 1'b1, 1'b0);
      cyc(1'b0, 2'b00, 1'b1, 1'b1, 1'b0);
      cyc(1'b0, 2'b00, 1'b1, 1'b1, 1'b0);
      chk_upd("swap.d4", 1'b1, 2'b11, 2'b10, 1'b1, 1'b0);
      chk("swap.err2", 8'(bus.bp_err), 8'h00);
      cyc(1'b0, 2'b00, 1'b1, 1'b1, 1'b0);
      chk("swap.empty", 8'(bus.bu_bp_update), 8'h00);

      // Asynchronous reset in the middle of a resolve.
      do_reset();
      for (int i = 0; i < 3; i++) begin
         cyc(1'b1, 2'b10, 1'b0, 1'b0, 1'b0);
      end
      cyc(1'b0, 2'b00, 1'b1, 1'b1, 1'b0);
      chk("arst.pre_upd", 8'(bus.bu_bp_update), 8'h01);
      bus.ex_br_resolve = 1'b1;
      bus.ex_br_taken   = 1'b1;
      @(negedge clk);
      rstn = 1'b0;
      #1;
      chk("arst.history", 8'(bus.bp_history), 8'h00);
      chk("arst.full",    8'(bus.bp_full),    8'h00);
      chk("arst.err",     8'(bus.bp_err),     8'h00);
      chk_upd("arst", 1'b0, 2'b00, 2'b00, 1'b0, 1'b0);
      bus.ex_br_resolve = 1'b0;
      bus.ex_br_taken   = 1'b0;
      @(posedge clk);
      #1;
      rstn = 1'b1;
      cyc(1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
      chk("arst.idle", 8'(bus.bu_bp_update), 8'h00);
      cyc(1'b0, 2'b00, 1'b1, 1'b1, 1'b0);
      chk("arst.no_upd", 8'(bus.bu_bp_update), 8'h00);
      chk("arst.err1",   8'(bus.bp_err),       8'h01);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
